// File: rtl/gcd_sched.sv
// Round-robin scheduler that shares one subtract-based GCD datapath between N requesters.
// Arbitrates, loads the winner's operands, runs the compare/subtract loop and returns the result with a one-cycle ack.
module gcd_sched #(
  parameter int N        = 4,
  parameter int W        = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] op_a,
  input  logic [N*W-1:0] op_b,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   result,
  output logic           result_err,
  output logic           busy,
  output logic           ldA,
  output logic           ldB,
  output logic           sel,
  output logic           sel_in,
  output logic [W-1:0]   dp_data,
  input  logic           gt,
  input  logic           lt,
  input  logic           eq,
  input  logic [W-1:0]   dp_gcd
);

  localparam int          IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [15:0] ITER_MAX = 16'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_CMP,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, b_q;
  logic [IW-1:0] g_q;
  logic [IW-1:0] rr_q;
  logic [15:0]   iter_q;

  logic          grant_vld;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] cand;
  logic [W-1:0]  op_a_arr [N];
  logic [W-1:0]  op_b_arr [N];
  logic [W-1:0]  op_a_sel, op_b_sel;
  logic          zero_job;
  logic          iter_hit;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign op_a_arr[i] = op_a[i*W +: W];
    assign op_b_arr[i] = op_b[i*W +: W];
  end

  // Scan from lowest to highest priority so the last hit (closest to rr+1) wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(rr_q) + k) % N);
      if (req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign op_a_sel = op_a_arr[grant_idx];
  assign op_b_sel = op_b_arr[grant_idx];
  assign zero_job = (op_a_sel == '0) || (op_b_sel == '0);
  assign iter_hit = (iter_q == ITER_MAX);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ack     = '0;
    busy    = (state_q != S_IDLE);
    ldA     = 1'b0;
    ldB     = 1'b0;
    sel     = 1'b0;
    sel_in  = 1'b0;
    dp_data = '0;
    unique case (state_q)
      S_IDLE: begin
        if (grant_vld) state_d = zero_job ? S_DONE : S_LOAD_A;
      end
      S_LOAD_A: begin
        sel_in  = 1'b1;
        dp_data = a_q;
        ldA     = 1'b1;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        sel_in  = 1'b1;
        dp_data = b_q;
        ldB     = 1'b1;
        state_d = S_CMP;
      end
      S_CMP: begin
        if (eq || iter_hit) begin
          state_d = S_DONE;
        end else if (gt) begin
          ldA = 1'b1;
        end else if (lt) begin
          ldB = 1'b1;
          sel = 1'b1;
        end
      end
      S_DONE: begin
        ack     = N'(1) << g_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: rst_n is sampled on the clock edge, so reset is an ordinary priority branch, not a sensitivity item.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      g_q        <= '0;
      rr_q       <= IW'(N - 1);
      iter_q     <= '0;
      result     <= '0;
      result_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the pre-edge values.
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            a_q    <= op_a_sel;
            b_q    <= op_b_sel;
            g_q    <= grant_idx;
            iter_q <= '0;
            if (zero_job) begin
              result     <= op_a_sel | op_b_sel;
              result_err <= 1'b0;
            end
          end
        end
        S_CMP: begin
          if (eq) begin
            result     <= dp_gcd;
            result_err <= 1'b0;
          end else if (iter_hit) begin
            result     <= '0;
            result_err <= 1'b1;
          end else begin
            // Also counts a cycle with no flag set, so a faulty datapath still aborts.
            iter_q <= iter_q + 16'd1;
          end
        end
        S_DONE:  rr_q <= g_q;
        default: ;
      endcase
    end
  end

endmodule
